dds_ddc_deadlock_supervisor: RTL and testbench

- Collects the per-instance `block` outputs of the DDS/DDC HLS deadlock monitors.
- Filters out transient stalls with a programmable persistence threshold.
- Latches one deadlock event: first blocking index, snapshot of all monitors, timestamp.
- Presents the event as a sticky interrupt plus a valid/ready report beat to the control/status block.

---
 rtl/dds_ddc_supervisor_pkg.sv | 20 ++
 rtl/dds_ddc_lsb_prienc.sv | 24 ++
 rtl/dds_ddc_deadlock_supervisor.sv | 135 +++++++++++++
 tb/tb_dds_ddc_deadlock_supervisor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_ddc_supervisor_pkg.sv
// Shared types and constants for the DDS/DDC deadlock supervisor.
// State encodings are fixed because software reads them through state_dbg.
package dds_ddc_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_PENDING  = 2'd1,
    ST_LATCHED  = 2'd2,
    ST_REPORTED = 2'd3
  } sup_state_e;

  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_SAT = 8'd255;

  localparam int DEF_N_MON    = 4;
  localparam int DEF_IDX_W    = 5;
  localparam int DEF_THRESH_W = 16;
  localparam int DEF_TS_W     = 32;

endpackage

// File: rtl/dds_ddc_lsb_prienc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest asserted
// bit of vec (0 when none) and a flag telling whether any bit is set.
module dds_ddc_lsb_prienc #(
  parameter int N_MON = 4,
  parameter int IDX_W = 5
) (
  input  logic [N_MON-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any_set
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any_set = |vec;

endmodule

// File: rtl/dds_ddc_deadlock_supervisor.sv
// Deadlock supervisor: filters persistent monitor blocking, latches one event
// (first index, snapshot, timestamp) and reports it as sticky irq + valid/ready beat.
module dds_ddc_deadlock_supervisor
  import dds_ddc_supervisor_pkg::*;
#(
  parameter int N_MON    = DEF_N_MON,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int THRESH_W = DEF_THRESH_W,
  parameter int TS_W     = DEF_TS_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_MON-1:0]    mon_block,
  input  logic [N_MON-1:0]    mon_enable,
  input  logic [THRESH_W-1:0] thresh,
  input  logic                clear,
  output logic                deadlock_irq,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [IDX_W-1:0]    report_idx,
  output logic [N_MON-1:0]    report_snap,
  output logic [TS_W-1:0]     report_ts,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic [1:0]          state_dbg
);

  sup_state_e          state_reg;
  logic [N_MON-1:0]    masked_q;
  logic [TS_W-1:0]     ts_reg;
  logic [THRESH_W-1:0] cnt_reg;
  logic [IDX_W-1:0]    cand_idx_reg;

  logic [IDX_W-1:0]    low_idx;
  logic                any_set;
  logic [THRESH_W-1:0] eff_thresh;
  logic [THRESH_W-1:0] cnt_inc;
  logic [TS_W-1:0]     ts_next;

  dds_ddc_lsb_prienc #(
    .N_MON (N_MON),
    .IDX_W (IDX_W)
  ) u_prienc (
    .vec     (masked_q),
    .idx     (low_idx),
    .any_set (any_set)
  );

  assign eff_thresh = (thresh == '0) ? THRESH_W'(1) : thresh;
  assign cnt_inc    = (cnt_reg == '1) ? cnt_reg : cnt_reg + THRESH_W'(1);
  assign ts_next    = ts_reg + TS_W'(1);
  assign state_dbg  = state_reg;

  // The captured timestamp is the one of the cycle in which the irq first shows.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_ARMED;
      masked_q     <= '0;
      ts_reg       <= '0;
      cnt_reg      <= '0;
      cand_idx_reg <= '0;
      deadlock_irq <= 1'b0;
      report_valid <= 1'b0;
      report_idx   <= '0;
      report_snap  <= '0;
      report_ts    <= '0;
      glitch_cnt   <= '0;
    end else begin
      masked_q <= mon_block & mon_enable;
      ts_reg   <= ts_next;
      if (clear) begin
        state_reg    <= ST_ARMED;
        cnt_reg      <= '0;
        cand_idx_reg <= '0;
        deadlock_irq <= 1'b0;
        report_valid <= 1'b0;
        report_idx   <= '0;
        report_snap  <= '0;
        report_ts    <= '0;
        glitch_cnt   <= '0;
      end else begin
        case (state_reg)
          ST_ARMED: begin
            if (any_set) begin
              cnt_reg      <= THRESH_W'(1);
              cand_idx_reg <= low_idx;
              if (eff_thresh == THRESH_W'(1)) begin
                state_reg    <= ST_LATCHED;
                report_idx   <= low_idx;
                report_snap  <= masked_q;
                report_ts    <= ts_next;
                deadlock_irq <= 1'b1;
                report_valid <= 1'b1;
              end else begin
                state_reg <= ST_PENDING;
              end
            end
          end
          ST_PENDING: begin
            if (!any_set) begin
              state_reg <= ST_ARMED;
              cnt_reg   <= '0;
              if (glitch_cnt != GLITCH_SAT) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
              end
            end else begin
              cnt_reg <= cnt_inc;
              // cand_idx stays on the episode's first blocker even if it recovers.
              if (cnt_inc == eff_thresh) begin
                state_reg    <= ST_LATCHED;
                report_idx   <= cand_idx_reg;
                report_snap  <= masked_q;
                report_ts    <= ts_next;
                deadlock_irq <= 1'b1;
                report_valid <= 1'b1;
              end
            end
          end
          ST_LATCHED: begin
            if (report_ready) begin
              report_valid <= 1'b0;
              state_reg    <= ST_REPORTED;
            end
          end
          ST_REPORTED: begin
            state_reg <= ST_REPORTED;
          end
          default: begin
            state_reg <= ST_ARMED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_ddc_deadlock_supervisor.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against an episode-level behavioural model of the supervisor.
module tb_dds_ddc_deadlock_supervisor;

  localparam int N  = 4;
  localparam int IW = 5;
  localparam int TW = 16;
  localparam int SW = 32;

  logic          clock        = 1'b0;
  logic          reset        = 1'b1;
  logic [N-1:0]  mon_block    = '0;
  logic [N-1:0]  mon_enable   = '0;
  logic [TW-1:0] thresh       = '0;
  logic          clear        = 1'b0;
  logic          report_ready = 1'b0;
  logic          deadlock_irq;
  logic          report_valid;
  logic [IW-1:0] report_idx;
  logic [N-1:0]  report_snap;
  logic [SW-1:0] report_ts;
  logic [7:0]    glitch_cnt;
  logic [1:0]    state_dbg;

  dds_ddc_deadlock_supervisor dut (
    .clock        (clock),
    .reset        (reset),
    .mon_block    (mon_block),
    .mon_enable   (mon_enable),
    .thresh       (thresh),
    .clear        (clear),
    .deadlock_irq (deadlock_irq),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_idx   (report_idx),
    .report_snap  (report_snap),
    .report_ts    (report_ts),
    .glitch_cnt   (glitch_cnt),
    .state_dbg    (state_dbg)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Episode-level model: run length of consecutive blocked samples, one latched event.
  int            m_run;
  int            m_glitch;
  logic [N-1:0]  m_prev;
  logic [IW-1:0] m_first;
  logic          m_irq;
  logic          m_valid;
  logic [IW-1:0] m_idx;
  logic [N-1:0]  m_snap;
  logic [SW-1:0] m_ts;
  logic [SW-1:0] m_rts;

  function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return IW'(i);
    end
    return '0;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_valid) return 2'd2;
    if (m_irq) return 2'd3;
    if (m_run > 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic void model_step();
    int eff;
    if (reset) begin
      m_run = 0; m_glitch = 0; m_prev = '0; m_first = '0; m_irq = 1'b0; m_valid = 1'b0;
      m_idx = '0; m_snap = '0; m_ts = '0; m_rts = '0;
      return;
    end
    eff = (thresh == '0) ? 1 : int'(thresh);
    if (clear) begin
      m_irq = 1'b0; m_valid = 1'b0; m_idx = '0; m_snap = '0; m_rts = '0;
      m_glitch = 0; m_run = 0;
    end else if (!m_irq) begin
      if (m_prev != '0) begin
        if (m_run == 0) m_first = lowest(m_prev);
        if (m_run < 65535) m_run++;
        if (m_run == eff) begin
          m_irq = 1'b1; m_valid = 1'b1; m_idx = m_first; m_snap = m_prev; m_rts = m_ts + 1;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end else if (m_valid && report_ready) begin
      m_valid = 1'b0;
    end
    m_prev = mon_block & mon_enable;
    m_ts   = m_ts + 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    cyc = reset ? 0 : cyc + 1;
    #1;
  endtask

  task automatic pulse_clear();
    mon_block = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mon_enable = '1;
    repeat (3) tick();
    vectors++;
    if ({deadlock_irq, report_valid, report_idx, report_snap, report_ts, glitch_cnt, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: irq=%b valid=%b idx=%0d snap=%b ts=%0d glitch=%0d state=%0d, all required 0",
               deadlock_irq, report_valid, report_idx, report_snap, report_ts, glitch_cnt, state_dbg);
    end
    reset = 1'b0;
  endtask

  task automatic test_steady();
    int seen;
    thresh = 8; report_ready = 1'b1; mon_block = '0; mon_enable = '1;
    while (cyc < 10) tick();
    mon_block = 4'b0100;
    seen = -1;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      tick();
      if (deadlock_irq === 1'b1) seen = cyc;
    end
    vectors++;
    if (seen != 19) begin
      miscompares++; $display("FAIL steady_irq_cycle: got %0d, required 19", seen);
    end
    vectors++;
    if ({report_valid, report_idx, report_snap, report_ts, state_dbg} !== {1'b1, 5'd2, 4'b0100, 32'd19, 2'd2}) begin
      miscompares++;
      $display("FAIL steady_report: valid=%b idx=%0d snap=%b ts=%0d state=%0d, required 1/2/0100/19/2",
               report_valid, report_idx, report_snap, report_ts, state_dbg);
    end
    tick();
    vectors++;
    if ({state_dbg, report_valid, deadlock_irq} !== {2'd3, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL steady_reported: state=%0d valid=%b irq=%b, required 3/0/1", state_dbg, report_valid, deadlock_irq);
    end
  endtask

  task automatic test_glitch();
    pulse_clear();
    thresh = 8; report_ready = 1'b0;
    mon_block = 4'b0001; repeat (3) tick();
    mon_block = '0; repeat (3) tick();
    vectors++;
    if ({deadlock_irq, glitch_cnt, state_dbg} !== {1'b0, 8'd1, 2'd0}) begin
      miscompares++;
      $display("FAIL glitch_single: irq=%b glitch=%0d state=%0d, required 0/1/0", deadlock_irq, glitch_cnt, state_dbg);
    end
    repeat (300) begin
      mon_block = 4'b0001; repeat (3) tick();
      mon_block = '0; repeat (2) tick();
    end
    vectors++;
    if ({deadlock_irq, glitch_cnt} !== {1'b0, 8'd255}) begin
      miscompares++;
      $display("FAIL glitch_saturate: irq=%b glitch=%0d, required 0/255", deadlock_irq, glitch_cnt);
    end
  endtask

  task automatic test_mask_backpressure();
    logic [SW-1:0] rise_ts;
    pulse_clear();
    mon_enable = 4'b1110; thresh = 1; report_ready = 1'b0; mon_block = 4'b0011;
    tick();
    vectors++;
    if (deadlock_irq !== 1'b0) begin
      miscompares++; $display("FAIL mask_early_irq: got %b, required 0", deadlock_irq);
    end
    tick();
    rise_ts = SW'(cyc);
    vectors++;
    if ({deadlock_irq, report_valid, report_idx, report_snap, report_ts} !== {1'b1, 1'b1, 5'd1, 4'b0010, rise_ts}) begin
      miscompares++;
      $display("FAIL mask_latch: irq=%b valid=%b idx=%0d snap=%b ts=%0d, required 1/1/1/0010/%0d",
               deadlock_irq, report_valid, report_idx, report_snap, report_ts, rise_ts);
    end
    for (int k = 0; k < 20; k++) begin
      mon_block = N'($urandom);
      mon_enable = N'($urandom);
      tick();
      vectors++;
      if ({deadlock_irq, report_valid, report_idx, report_snap, report_ts, state_dbg} !== {1'b1, 1'b1, 5'd1, 4'b0010, rise_ts, 2'd2}) begin
        miscompares++;
        $display("FAIL backpressure_hold k=%0d: irq=%b valid=%b idx=%0d snap=%b ts=%0d state=%0d, required 1/1/1/0010/%0d/2",
                 k, deadlock_irq, report_valid, report_idx, report_snap, report_ts, state_dbg, rise_ts);
      end
    end
    report_ready = 1'b1; tick(); report_ready = 1'b0;
    vectors++;
    if ({report_valid, deadlock_irq, state_dbg, report_idx, report_snap} !== {1'b0, 1'b1, 2'd3, 5'd1, 4'b0010}) begin
      miscompares++;
      $display("FAIL backpressure_release: valid=%b irq=%b state=%0d idx=%0d snap=%b, required 0/1/3/1/0010",
               report_valid, deadlock_irq, state_dbg, report_idx, report_snap);
    end
  endtask

  task automatic test_clear_races();
    int seen;
    pulse_clear();
    mon_enable = '1; thresh = 1; report_ready = 1'b0; mon_block = 4'b1000;
    tick(); tick();
    vectors++;
    if (state_dbg !== 2'd2) begin
      miscompares++; $display("FAIL race_setup_latched: state=%0d, required 2", state_dbg);
    end
    mon_block = '0; clear = 1'b1; report_ready = 1'b1;
    tick();
    clear = 1'b0; report_ready = 1'b0;
    vectors++;
    if ({state_dbg, report_valid, deadlock_irq, report_idx, report_snap, report_ts} !== '0) begin
      miscompares++;
      $display("FAIL race_clear_vs_ready: state=%0d valid=%b irq=%b idx=%0d snap=%b ts=%0d, all required 0",
               state_dbg, report_valid, deadlock_irq, report_idx, report_snap, report_ts);
    end
    thresh = 8; mon_block = 4'b0010;
    repeat (6) tick();
    vectors++;
    if (state_dbg !== 2'd1) begin
      miscompares++; $display("FAIL race_pending_setup: state=%0d, required 1", state_dbg);
    end
    mon_block = '0; clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({state_dbg, glitch_cnt, deadlock_irq} !== {2'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL race_clear_pending: state=%0d glitch=%0d irq=%b, required 0/0/0", state_dbg, glitch_cnt, deadlock_irq);
    end
    mon_block = 4'b0010;
    seen = -1;
    for (int k = 1; k <= 30 && seen < 0; k++) begin
      tick();
      if (deadlock_irq === 1'b1) seen = k;
    end
    vectors++;
    if (seen != 9) begin
      miscompares++; $display("FAIL race_count_restart: irq after %0d cycles, required 9", seen);
    end
  endtask

  task automatic test_reset_mid_pending();
    pulse_clear();
    thresh = 8; mon_enable = '1; mon_block = 4'b0001;
    repeat (4) tick();
    vectors++;
    if (state_dbg !== 2'd1) begin
      miscompares++; $display("FAIL rst_mid_setup: state=%0d, required 1", state_dbg);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if ({deadlock_irq, report_valid, report_idx, report_snap, report_ts, glitch_cnt, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: irq=%b valid=%b idx=%0d snap=%b ts=%0d glitch=%0d state=%0d, all required 0",
               deadlock_irq, report_valid, report_idx, report_snap, report_ts, glitch_cnt, state_dbg);
    end
    thresh = 0; mon_block = 4'b1000;
    tick();
    vectors++;
    if (deadlock_irq !== 1'b0) begin
      miscompares++; $display("FAIL thresh0_early: irq=%b, required 0", deadlock_irq);
    end
    tick();
    vectors++;
    if ({deadlock_irq, report_idx, report_snap, report_ts} !== {1'b1, 5'd3, 4'b1000, 32'd2}) begin
      miscompares++;
      $display("FAIL thresh0_latch: irq=%b idx=%0d snap=%b ts=%0d, required 1/3/1000/2",
               deadlock_irq, report_idx, report_snap, report_ts);
    end
  endtask

  task automatic test_random();
    pulse_clear();
    mon_enable = '1; thresh = 3;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) mon_block = N'($urandom);
      if ($urandom_range(31) == 0) mon_enable = N'($urandom);
      if ($urandom_range(63) == 0) thresh = TW'($urandom_range(6));
      report_ready = ($urandom_range(2) == 0);
      clear = ($urandom_range(59) == 0);
      tick();
      vectors++;
      if ({deadlock_irq, report_valid, report_idx, report_snap, report_ts, glitch_cnt, state_dbg} !==
          {m_irq, m_valid, m_idx, m_snap, m_rts, 8'(m_glitch), m_state()}) begin
        miscompares++;
        $display("FAIL random k=%0d: got irq=%b valid=%b idx=%0d snap=%b ts=%0d glitch=%0d state=%0d; required %b %b %0d %b %0d %0d %0d",
                 k, deadlock_irq, report_valid, report_idx, report_snap, report_ts, glitch_cnt, state_dbg,
                 m_irq, m_valid, m_idx, m_snap, m_rts, m_glitch, m_state());
      end
    end
    clear = 1'b0; report_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_glitch();
    test_mask_backpressure();
    test_clear_races();
    test_reset_mid_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
